// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Multicycle main control FSM for the MIPS datapath. Steps each instruction
//   through fetch, decode, execute, memory and writeback states. It drives every
//   datapath enable and mux select, and it stalls on the memory-ready handshake.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   opcode          : IR opcode field, sampled in DECODE
//   mem_ready       : memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   pc_source[1:0], OpALU[1:0] : datapath controls, decoded from the state
//   illegal_op      : one-cycle pulse in DECODE on an unrecognised opcode
//   state_dbg       : current state encoding
//   instr_count     : retired-instruction count, wraps modulo 2^CNT_W
//
// Build option
//   MIPS_CTRL_ADDI_EN : when defined, addi is handled through ADDI_EX/ADDI_WB.
//                       Otherwise opcode 001000 is treated as illegal.

module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [1:0]       OpALU,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_e;

    state_e             state_q, state_d;
    logic               is_lw_q, is_lw_d;   // lw vs sw, captured in DECODE for MEM_ADDR
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            is_lw_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        is_lw_d       = is_lw_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        OpALU         = 2'b00;
        illegal_op    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC+4 load only when the fetch actually completes.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                is_lw_d   = (opcode == OP_LW);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                OpALU     = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                OpALU         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            // Unused encodings (and ADDI states when addi is disabled) recover
            // to FETCH with all outputs low.
            default: state_d = S_FETCH;
        endcase
    end

    // An instruction retires when a completing state hands back to FETCH.
    // IDLE->FETCH and illegal-op returns from DECODE are excluded.
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEM_WB, S_MEM_WRITE, S_R_WB,
                S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
                default:                     retire = 1'b0;
            endcase
        end
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign state_dbg   = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

    localparam int CW = 4;

    localparam int IDLE = 0, FETCH = 1, DECODE = 2, MADDR = 3, MREAD = 4, MWB = 5,
                   MWRITE = 6, EXEC = 7, RWB = 8, BRANCH = 9, JUMP = 10,
                   AEX = 11, AWB = 12;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_BAD = 6'b111111;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] opcode;
    logic mem_ready;
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source, OpALU;
    logic [3:0] state_dbg;
    logic [CW-1:0] instr_count;

    mips_multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .OpALU(OpALU), .illegal_op(illegal_op), .state_dbg(state_dbg),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    st;
        logic [16:0]   outs;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_m  = 0;   // model of retired instructions

    function automatic bit is_legal(logic [5:0] op);
        bit l;
        l = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_CTRL_ADDI_EN
        l = l || (op == OP_ADDI);
`endif
        return l;
    endfunction

    // Control word expected for a state, straight from the per-state table.
    function automatic logic [16:0] exp_outs(int st, bit mr, bit ill);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, il;
        logic [1:0] asb, psrc, alu;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, il} = '0;
        asb = 2'b00; psrc = 2'b00; alu = 2'b00;
        case (st)
            FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            DECODE: begin asb = 2'b11; il = ill; end
            MADDR:  begin asa = 1; asb = 2'b10; end
            MREAD:  begin mrd = 1; iod = 1; end
            MWB:    begin rw = 1; m2r = 1; end
            MWRITE: begin mwr = 1; iod = 1; end
            EXEC:   begin asa = 1; alu = 2'b10; end
            RWB:    begin rw = 1; rd = 1; end
            BRANCH: begin asa = 1; alu = 2'b01; pwc = 1; psrc = 2'b01; end
            JUMP:   begin pw = 1; psrc = 2'b10; end
            AEX:    begin asa = 1; asb = 2'b10; end
            AWB:    begin rw = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, psrc, alu, il};
    endfunction

    task automatic push(int st, bit mr, bit ill);
        exp_t e;
        e.st   = st[3:0];
        e.outs = exp_outs(st, mr, ill);
        e.cnt  = cnt_m[CW-1:0];
        q.push_back(e);
    endtask

    // One clock of stimulus; records what the DUT must show during that cycle.
    task automatic cyc(int st, bit mr, logic [5:0] op, bit ill);
        @(posedge clk); #1;
        mem_ready = mr;
        opcode    = op;
        push(st, mr, ill);
    endtask

    task automatic retire();
        cnt_m = (cnt_m + 1) % (1 << CW);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(logic [5:0] op, int fst, int mst);
        for (int i = 0; i < fst; i++) cyc(FETCH, 0, 6'($urandom), 0);
        cyc(FETCH, 1, 6'($urandom), 0);
        cyc(DECODE, rb(), op, !is_legal(op));
        if (!is_legal(op)) return;
        case (op)
            OP_R:   begin cyc(EXEC, rb(), op, 0); cyc(RWB, rb(), op, 0); end
            OP_LW:  begin
                cyc(MADDR, rb(), op, 0);
                for (int i = 0; i < mst; i++) cyc(MREAD, 0, op, 0);
                cyc(MREAD, 1, op, 0);
                cyc(MWB, rb(), op, 0);
            end
            OP_SW:  begin
                cyc(MADDR, rb(), op, 0);
                for (int i = 0; i < mst; i++) cyc(MWRITE, 0, op, 0);
                cyc(MWRITE, 1, op, 0);
            end
            OP_BEQ: cyc(BRANCH, rb(), op, 0);
            OP_J:   cyc(JUMP, rb(), op, 0);
            default: begin cyc(AEX, rb(), op, 0); cyc(AWB, rb(), op, 0); end
        endcase
        retire();
    endtask

    // sw aborted by reset while waiting in MEM_WRITE.
    task automatic sw_abort();
        cyc(FETCH, 1, OP_SW, 0);
        cyc(DECODE, 0, OP_SW, 0);
        cyc(MADDR, 0, OP_SW, 0);
        cyc(MWRITE, 0, OP_SW, 0);
        cyc(MWRITE, 0, OP_SW, 0);
        @(posedge clk); #1;
        rst_n = 0; mem_ready = 1; cnt_m = 0;
        push(IDLE, 1, 0);
        @(posedge clk); #1;
        push(IDLE, 1, 0);
        rst_n = 1;
    endtask

    // Monitor: every cycle the DUT presents a state; compare against the queue head.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (state_dbg !== e.st) begin
                errors++;
                $display("FAIL state t=%0t got %0d want %0d", $time, state_dbg, e.st);
            end
            checks++;
            if ({pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, OpALU, illegal_op} !== e.outs) begin
                errors++;
                $display("FAIL ctrl t=%0t st=%0d got %05h want %05h", $time, e.st,
                         {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                          reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, OpALU, illegal_op}, e.outs);
            end
            checks++;
            if (instr_count !== e.cnt) begin
                errors++;
                $display("FAIL instr_count t=%0t got %0d want %0d", $time, instr_count, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [8];
        rst_n = 0; mem_ready = 0; opcode = 6'd0;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BAD, 6'b110011};
        // Reset state, then IDLE for one cycle after release.
        cyc(IDLE, 1, OP_R, 0);
        cyc(IDLE, 0, OP_LW, 0);
        @(posedge clk); #1;
        rst_n = 1;
        push(IDLE, mem_ready, 0);

        run_instr(OP_R, 0, 0);
        run_instr(OP_LW, 0, 2);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_BAD, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_J, 4, 0);
        run_instr(OP_SW, 1, 3);
        sw_abort();
        for (int i = 0; i < 16; i++) run_instr(OP_J, 0, 0);   // count wraps to 0
        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        cyc(FETCH, 0, 6'd0, 0);

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select, including the 2-bit OpALU code consumed by the ALU control decoder.
- Sits between the instruction register opcode field and the datapath; stalls on a memory-ready handshake.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instruction opcode field from the instruction register; sampled only in DECODE
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  register write data select: 1 = MDR, 0 = ALUOut
reg_dst  output  1  destination select: 1 = rd, 0 = rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
OpALU  output  2  00 = add, 01 = subtract, 10 = decode by funct
illegal_op  output  1  one-cycle pulse on an unrecognised opcode
state_dbg  output  4  current state encoding
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12.
- Reset (async, rst_n low): state IDLE, instr_count 0, every output 0.
- IDLE moves to FETCH on the first clock after rst_n deasserts.
- Outputs are decoded from the current state only, with two exceptions qualified by mem_ready (see FETCH). Any signal not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, OpALU=00, pc_source=00.
  - ir_write and pc_write are 1 only in the cycle mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, OpALU=00.
  - Branch on opcode: lw/sw -> MEM_ADDR, R -> EXECUTE, beq -> BRANCH, j -> JUMP, addi -> ADDI_EX.
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, OpALU=00. Go to MEM_READ for lw, MEM_WRITE for sw; this uses the opcode held in the IR.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready=1, then go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, OpALU=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, OpALU=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, OpALU=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- Latency: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4. Each memory state adds one cycle per cycle of mem_ready=0.
- instr_count: increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE (completion), R_WB, BRANCH, JUMP or ADDI_WB.
  - Wraps from 2^CNT_W-1 to 0.
  - The IDLE->FETCH transition and illegal-op returns do not count.
- Unused encodings 13-15 return to FETCH on the next clock with all outputs 0.
- rst_n asserted mid-instruction: immediate IDLE, outputs cleared, no partial write completes afterwards.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.

Optional Feature:
MIPS_CTRL_ADDI_EN
- Defined: addi decodes as above through ADDI_EX and ADDI_WB.
- Undefined: ADDI_EX and ADDI_WB are not implemented; opcode 001000 is treated as illegal (illegal_op pulse, return to FETCH, not counted).

Test Plan:
- Reset, then R-type (000000) with mem_ready=1 -> states 0,1,2,7,8,1; OpALU=10 in EXECUTE; reg_write=1 and reg_dst=1 in R_WB; instr_count=1.
- lw with mem_ready low 2 cycles in MEM_READ -> MEM_READ held 3 cycles; mem_to_reg=1 and reg_write=1 once; total 7 cycles; instr_count +1.
- beq -> BRANCH has OpALU=01, pc_write_cond=1, pc_source=01; 3 cycles fetch-to-fetch.
- Opcode 111111 -> illegal_op high exactly 1 cycle in DECODE, next state FETCH, instr_count unchanged; same for addi with MIPS_CTRL_ADDI_EN undefined.
- FETCH with mem_ready=0 for 4 cycles -> ir_write and pc_write stay 0; both pulse 1 cycle when mem_ready=1.
- rst_n low during MEM_WRITE -> all outputs 0 immediately; instr_count 0; FETCH one cycle after release. Separately, with CNT_W=4, 16 j instructions -> instr_count wraps to 0.
